// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage of the single-cycle MIPS core, sitting directly
// upstream of the control decoder. It holds the PC and fetches one word at a
// time from instruction memory over a req/ack handshake. It presents that
// word to the decoder until execute retires it, and then advances the PC
// using the decoder's NPCOp.
//
// Parameters:
//   RESET_PC    PC loaded on reset (bits [1:0] must be 00)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   NPCOp       next-PC op from the decoder (00 PLUS4, 01 BRANCH, 10 JUMP,
//               11 treated as PLUS4); only looked at on the retire cycle
//   im_req      instruction-memory read request
//   im_addr     fetch address (pc with [1:0] forced to 00)
//   im_ack      memory has im_rdata valid this cycle
//   im_rdata    instruction word from memory
//   instr       registered instruction (Op = [31:26], Funct = [5:0])
//   instr_valid instr holds a fetched, not yet retired instruction
//   exec_ready  execute retires instr this cycle
//   pc          address of the current / in-flight instruction
//   pc_plus4    pc + 4
//   retire_cnt  number of retired instructions (wraps)
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  NPCOp,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        fetch_done;
    logic        retire;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    // A fetch only completes while a request is outstanding, so acks seen in
    // RESET or HOLD are simply dropped. Likewise exec_ready only matters once
    // a valid instruction is being held.
    assign fetch_done = (state == ST_FETCH) && im_ack;
    assign retire     = (state == ST_HOLD) && instr_valid && exec_ready;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign im_addr    = {pc[31:2], 2'b00};

    // Next-PC selection from the decoder's NPCOp. The reserved encoding falls
    // through to sequential fetch. All arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        case (NPCOp)
            2'b01:   next_pc = pc_plus4 + branch_off;
            2'b10:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // State register. Reset always returns to ST_RESET, which also aborts
    // any request that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and request logic. The request is a pure function of the
    // state, so im_req drops the cycle after an ack and rises again the cycle
    // after a retire.
    always_comb begin
        state_next = state;
        im_req     = 1'b0;
        case (state)
            ST_RESET: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ack) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

    // Datapath registers. instr is only written on a completed fetch, which
    // can only happen while instr_valid is low, so a held instruction is
    // never overwritten. pc only moves on retire, which keeps im_addr stable
    // for the whole fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0000_0000;
            instr_valid <= 1'b0;
            retire_cnt  <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                instr       <= im_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                retire_cnt  <= retire_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit. A table of fetch/retire transactions walks
// the PC through sequential, branch and jump updates (including memory wait
// states and execute stalls). Hand-written sequences then cover reset in the
// middle of FETCH and HOLD, PC wrap and retire-counter wrap.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  NPCOp;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retire_cnt;

    int          total_checks;
    int          bad_checks;
    logic [31:0] exp_cnt;

    typedef struct {
        logic [31:0] rdata;
        int          waits;
        int          stalls;
        logic [1:0]  op;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[11];

    ifetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .NPCOp      (NPCOp),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_ready (exec_ready),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .retire_cnt (retire_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One full transaction starting at a falling edge where the unit is in
    // FETCH: optional wait states, ack, optional execute stalls, retire.
    // Spurious exec_ready during FETCH and spurious acks during HOLD are
    // injected to show they are ignored.
    task automatic applyStimulus(input vec_t v);
        checkOutput("fetch_req", {31'd0, im_req}, 32'd1);
        checkOutput("fetch_addr", im_addr, v.exp_pc);
        checkOutput("fetch_pc", pc, v.exp_pc);
        checkOutput("fetch_plus4", pc_plus4, v.exp_pc + 32'd4);
        for (int w = 0; w < v.waits; w++) begin
            im_ack     = 1'b0;
            exec_ready = 1'b1;
            @(negedge clk);
            checkOutput("wait_addr", im_addr, v.exp_pc);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        exec_ready = 1'b0;
        im_ack     = 1'b1;
        im_rdata   = v.rdata;
        @(negedge clk);
        im_ack = 1'b0;
        checkOutput("hold_instr", instr, v.rdata);
        checkOutput("hold_valid", {31'd0, instr_valid}, 32'd1);
        checkOutput("hold_req", {31'd0, im_req}, 32'd0);
        for (int s = 0; s < v.stalls; s++) begin
            im_ack   = 1'b1;
            im_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput("stall_instr", instr, v.rdata);
            checkOutput("stall_req", {31'd0, im_req}, 32'd0);
            checkOutput("stall_pc", pc, v.exp_pc);
        end
        im_ack     = 1'b0;
        exec_ready = 1'b1;
        NPCOp      = v.op;
        @(negedge clk);
        exec_ready = 1'b0;
        NPCOp      = 2'b00;
        exp_cnt    = exp_cnt + 32'd1;
        checkOutput("retire_pc", pc, v.exp_next);
        checkOutput("retire_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("retire_req", {31'd0, im_req}, 32'd1);
        checkOutput("retire_cnt", retire_cnt, exp_cnt);
    endtask

    // Checks the complete reset state.
    task automatic checkReset(input string tag);
        checkOutput({tag, "_pc"}, pc, 32'h0000_0000);
        checkOutput({tag, "_instr"}, instr, 32'h0000_0000);
        checkOutput({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        checkOutput({tag, "_req"}, {31'd0, im_req}, 32'd0);
        checkOutput({tag, "_cnt"}, retire_cnt, 32'h0000_0000);
    endtask

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        exp_cnt      = 32'd0;
        rst          = 1'b1;
        NPCOp        = 2'b00;
        im_ack       = 1'b0;
        im_rdata     = 32'h0;
        exec_ready   = 1'b0;

        // rdata, waits, stalls, NPCOp, pc, expected next pc
        vecs[0]  = '{32'h2008_0005, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0004};
        vecs[1]  = '{32'h0800_0004, 0, 0, 2'b10, 32'h0000_0004, 32'h0000_0010};
        vecs[2]  = '{32'h0000_0020, 3, 5, 2'b00, 32'h0000_0010, 32'h0000_0014};
        vecs[3]  = '{32'h0800_0010, 1, 1, 2'b10, 32'h0000_0014, 32'h0000_0040};
        vecs[4]  = '{32'h1000_FFFE, 0, 0, 2'b01, 32'h0000_0040, 32'h0000_003C};
        vecs[5]  = '{32'h1000_0003, 0, 2, 2'b01, 32'h0000_003C, 32'h0000_004C};
        vecs[6]  = '{32'h0800_0020, 2, 0, 2'b10, 32'h0000_004C, 32'h0000_0080};
        vecs[7]  = '{32'h0000_0000, 0, 0, 2'b11, 32'h0000_0080, 32'h0000_0084};
        vecs[8]  = '{32'h0BFF_FFFF, 0, 0, 2'b10, 32'h0000_0084, 32'h0FFF_FFFC};
        vecs[9]  = '{32'h0000_0000, 0, 0, 2'b00, 32'h0FFF_FFFC, 32'h1000_0000};
        vecs[10] = '{32'h0800_0010, 0, 0, 2'b10, 32'h1000_0000, 32'h1000_0040};

        // Power-on reset, with a stray ack that must be ignored.
        @(negedge clk);
        im_ack = 1'b1;
        @(negedge clk);
        im_ack = 1'b0;
        checkReset("por");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset while FETCH has a request out and memory acks in that cycle.
        im_ack   = 1'b1;
        im_rdata = 32'h1234_5678;
        rst      = 1'b1;
        @(negedge clk);
        im_ack = 1'b0;
        checkReset("rst_fetch");
        exp_cnt = 32'd0;
        rst     = 1'b0;
        @(negedge clk);

        applyStimulus('{32'h2008_0005, 0, 0, 2'b00, 32'h0000_0000, 32'h0000_0004});

        // Reset while HOLD sees exec_ready: the retire must not happen.
        im_ack   = 1'b1;
        im_rdata = 32'h0800_0004;
        @(negedge clk);
        im_ack     = 1'b0;
        exec_ready = 1'b1;
        NPCOp      = 2'b10;
        rst        = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        NPCOp      = 2'b00;
        checkReset("rst_hold");
        exp_cnt = 32'd0;
        rst     = 1'b0;
        @(negedge clk);

        // Branch backwards below zero, then sequential fetch off the top.
        applyStimulus('{32'h1000_FFFE, 0, 0, 2'b01, 32'h0000_0000, 32'hFFFF_FFFC});
        applyStimulus('{32'h0000_0000, 1, 0, 2'b00, 32'hFFFF_FFFC, 32'h0000_0000});

        // Retire counter wrap: preload the counter to all-ones while holding.
        im_ack   = 1'b1;
        im_rdata = 32'h0000_0000;
        @(negedge clk);
        im_ack = 1'b0;
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        checkOutput("cnt_preload", retire_cnt, 32'hFFFF_FFFF);
        exec_ready = 1'b1;
        @(negedge clk);
        exec_ready = 1'b0;
        checkOutput("cnt_wrap", retire_cnt, 32'h0000_0000);
        checkOutput("cnt_wrap_pc", pc, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
